// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I+CSR core front end.
// Used by fetch, the immediate generator and the decoder.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    // Major opcodes, bits [6:0] of the instruction word
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    // Instruction word paired with the PC it was fetched from
    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus between fetch and the imem.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [ILEN-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load or bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  fetch_pkt_t      load_pkt_i,
    output logic [ILEN-1:0] inst_d,
    output logic [XLEN-1:0] pc_d,
    output logic            valid_d
);

    logic [ILEN-1:0] inst_q, inst_d_n;
    logic [XLEN-1:0] pc_q, pc_d_n;
    logic            valid_q, valid_d_n;

    // A bubble keeps the previous PC so decode never sees a stale-looking jump
    always_comb begin
        inst_d_n  = inst_q;
        pc_d_n    = pc_q;
        valid_d_n = valid_q;
        if (flush_i) begin
            inst_d_n  = NOP_INST;
            valid_d_n = 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                inst_d_n  = load_pkt_i.inst;
                pc_d_n    = load_pkt_i.pc;
                valid_d_n = 1'b1;
            end else begin
                inst_d_n  = NOP_INST;
                valid_d_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d_n;
            pc_q    <= pc_d_n;
            valid_q <= valid_d_n;
        end
    end

    assign inst_d  = inst_q;
    assign pc_d    = pc_q;
    assign valid_d = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, single-outstanding imem requests, redirect
// handling with a kill flag for in-flight responses, and a one-entry stall buffer.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter logic [ILEN-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                branch_taken_i,
    input  logic [XLEN-1:0]     branch_target_i,
    input  logic                trap_i,
    input  logic [XLEN-1:0]     mtvec_i,
    input  logic                mret_i,
    input  logic [XLEN-1:0]     mepc_i,
    fetch_stage_if.master       imem,
    output logic [ILEN-1:0]     inst_d,
    output logic [XLEN-1:0]     pc_d,
    output logic                valid_d
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [XLEN-1:0] pc_pend_q, pc_pend_d;
    logic            kill_q, kill_d;
    logic            hold_v_q, hold_v_d;
    fetch_pkt_t      hold_pkt_q, hold_pkt_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            req_c;
    logic            rsp_valid;
    logic            deliverable;
    fetch_pkt_t      rsp_pkt;
    logic            if_id_load;
    fetch_pkt_t      load_pkt;

    // Redirect priority: trap, then mret, then taken branch
    always_comb begin
        redirect = trap_i | mret_i | branch_taken_i;
        if (trap_i) begin
            target = align_word(mtvec_i);
        end else if (mret_i) begin
            target = align_word(mepc_i);
        end else begin
            target = align_word(branch_target_i);
        end
    end

    assign req_c       = (state_q == S_REQ) & ~hold_v_q & ~redirect;
    assign rsp_valid   = (state_q == S_WAIT) & imem.imem_rvalid_i;
    assign deliverable = rsp_valid & ~kill_q & ~redirect;
    assign rsp_pkt     = '{inst: imem.imem_rdata_i, pc: pc_pend_q};

    assign imem.imem_req_o  = req_c;
    assign imem.imem_addr_o = pc_f_q;

    // PC / request FSM; a redirect while a response is still owed arms the kill flag
    always_comb begin
        state_d   = state_q;
        pc_f_d    = pc_f_q;
        pc_pend_d = pc_pend_q;
        kill_d    = kill_q;
        case (state_q)
            S_REQ: begin
                if (req_c && imem.imem_gnt_i) begin
                    pc_pend_d = pc_f_q;
                    pc_f_d    = pc_f_q + XLEN'(4);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid_i) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
        endcase
        if (redirect) begin
            pc_f_d = target;
        end
    end

    // Stall buffer: parks a response that decode cannot take yet
    always_comb begin
        hold_v_d   = hold_v_q;
        hold_pkt_d = hold_pkt_q;
        if (redirect) begin
            hold_v_d = 1'b0;
        end else if (stall_i) begin
            if (deliverable) begin
                hold_v_d   = 1'b1;
                hold_pkt_d = rsp_pkt;
            end
        end else begin
            hold_v_d = 1'b0;
        end
    end

    assign if_id_load = hold_v_q | deliverable;
    assign load_pkt   = hold_v_q ? hold_pkt_q : rsp_pkt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_f_q     <= RESET_PC;
            pc_pend_q  <= '0;
            kill_q     <= 1'b0;
            hold_v_q   <= 1'b0;
            hold_pkt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_f_q     <= pc_f_d;
            pc_pend_q  <= pc_pend_d;
            kill_q     <= kill_d;
            hold_v_q   <= hold_v_d;
            hold_pkt_q <= hold_pkt_d;
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect),
        .stall_i    (stall_i),
        .load_i     (if_id_load),
        .load_pkt_i (load_pkt),
        .inst_d     (inst_d),
        .pc_d       (pc_d),
        .valid_d    (valid_d)
    );

endmodule
